// File: rtl/op_sequencer.sv
// Walks a run of operand pairs through an external operation unit and writes each result back.
// One element at a time: read operands, issue, wait for the result (with timeout), write it.
module op_sequencer #(
    parameter int MEM_DEPTH = 8,
    parameter int MEM_WIDTH = 32,
    parameter int TIMEOUT   = 16,
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AW-1:0]        base_i,
    input  logic [AW:0]          count_i,
    output logic [AW-1:0]        rd_addr_o,
    input  logic [MEM_WIDTH-1:0] operand1_i,
    input  logic [MEM_WIDTH-1:0] operand2_i,
    output logic                 op_valid_o,
    output logic [MEM_WIDTH-1:0] op_a_o,
    output logic [MEM_WIDTH-1:0] op_b_o,
    input  logic                 op_ready_i,
    input  logic                 res_valid_i,
    input  logic [MEM_WIDTH-1:0] res_i,
    output logic                 wr_en_o,
    output logic [AW-1:0]        wr_addr_o,
    output logic [MEM_WIDTH-1:0] wr_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(MEM_DEPTH - 1);
    localparam logic [AW:0]   DEPTH_CNT  = (AW + 1)'(MEM_DEPTH);
    localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [AW-1:0]        addr_reg, addr_next;
    logic [AW-1:0]        wr_addr_reg, wr_addr_next;
    logic [AW:0]          count_reg, count_next;
    logic [AW:0]          idx_reg, idx_next;
    logic [TW-1:0]        wait_cnt_reg, wait_cnt_next;
    logic [MEM_WIDTH-1:0] op_a_reg, op_a_next;
    logic [MEM_WIDTH-1:0] op_b_reg, op_b_next;
    logic [MEM_WIDTH-1:0] res_reg, res_next;
    logic                 err_reg, err_next;
    logic [AW-1:0]        base_mod;

    // base_i can exceed the last entry when MEM_DEPTH is not a power of two; fold it once.
    assign base_mod = ({1'b0, base_i} >= DEPTH_CNT) ? AW'({1'b0, base_i} - DEPTH_CNT) : base_i;

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        wr_addr_next  = wr_addr_reg;
        count_next    = count_reg;
        idx_next      = idx_reg;
        wait_cnt_next = wait_cnt_reg;
        op_a_next     = op_a_reg;
        op_b_next     = op_b_reg;
        res_next      = res_reg;
        err_next      = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    addr_next  = base_mod;
                    count_next = (count_i > DEPTH_CNT) ? DEPTH_CNT : count_i;
                    idx_next   = '0;
                    err_next   = 1'b0;
                    state_next = (count_i == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                op_a_next  = operand1_i;
                op_b_next  = operand2_i;
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (op_ready_i) begin
                    wait_cnt_next = '0;
                    state_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (res_valid_i) begin
                    res_next     = res_i;
                    wr_addr_next = addr_reg;
                    state_next   = S_WRITE;
                end else if (wait_cnt_reg == WAIT_LIMIT) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_WRITE: begin
                idx_next   = idx_reg + 1'b1;
                addr_next  = (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
                state_next = (idx_next == count_reg) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg    <= S_IDLE;
            addr_reg     <= '0;
            wr_addr_reg  <= '0;
            count_reg    <= '0;
            idx_reg      <= '0;
            wait_cnt_reg <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            res_reg      <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            wr_addr_reg  <= wr_addr_next;
            count_reg    <= count_next;
            idx_reg      <= idx_next;
            wait_cnt_reg <= wait_cnt_next;
            op_a_reg     <= op_a_next;
            op_b_reg     <= op_b_next;
            res_reg      <= res_next;
            err_reg      <= err_next;
        end
    end

    // Strobes decode straight from the state, so issue and write can never overlap.
    assign rd_addr_o  = addr_reg;
    assign op_valid_o = (state_reg == S_ISSUE);
    assign op_a_o     = op_a_reg;
    assign op_b_o     = op_b_reg;
    assign wr_en_o    = (state_reg == S_WRITE);
    assign wr_addr_o  = wr_addr_reg;
    assign wr_data_o  = res_reg;
    assign busy_o     = (state_reg != S_IDLE);
    assign done_o     = (state_reg == S_DONE);
    assign err_o      = err_reg;

endmodule
